// File: rtl/countdown_timer.sv
// Countdown timer: MM:SS preset via keys, centisecond countdown, blinking alarm at zero.
// Keys are active-low raw inputs, conditioned internally into one-cycle press events.

// Per-key conditioning: 2-flop sync, debounce, falling-edge press pulse.
module cdt_key_cond #(
  parameter int DEBOUNCE = 250000,
  parameter int DW       = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_vld_i,
  input  logic key_n_i,
  output logic press_o
);
  logic          s1_q, s2_q, lvl_q, lvl_d1_q, armed_q, press_q;
  logic [DW-1:0] cnt_q;

  // Sync, debounce and edge-detect. A press is only reported once the key has been
  // seen released since reset, so a key held through reset stays silent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      lvl_q    <= 1'b1;
      lvl_d1_q <= 1'b1;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= key_n_i;
      s2_q     <= s1_q;
      lvl_d1_q <= lvl_q;
      press_q  <= armed_q & lvl_d1_q & ~lvl_q;
      if (sync_vld_i) begin
        if (s2_q) armed_q <= 1'b1;
        if (s2_q != lvl_q) begin
          if (cnt_q == DW'(DEBOUNCE - 1)) begin
            lvl_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign press_o = press_q;
endmodule

module countdown_timer #(
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 250000,
  parameter int MAX_TIME = 359999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key2,
  input  logic        key1,
  input  logic        key0,
  output logic [18:0] time_remaining,
  output logic        running,
  output logic        alarm,
  output logic [9:0]  led
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_ALARM} state_t;

  state_t        state_q, state_d;
  logic [18:0]   time_q, time_d, preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d, presc_adv;
  logic [6:0]    blink_q, blink_d;
  logic          running_q, alarm_q;
  logic [9:0]    led_q, led_d;
  logic [1:0]    sv_q;
  logic [2:0]    key_raw, ev;
  logic          tick;
  logic [18:0]   secs_q, sec, sum, secs_d;
  logic [3:0]    dig;

  assign key_raw = {key2, key1, key0};

  // Marks when the sync chains hold real samples after reset.
  always_ff @(posedge clk) begin
    if (rst) sv_q <= 2'b00;
    else     sv_q <= {sv_q[0], 1'b1};
  end

  for (genvar k = 0; k < 3; k++) begin : g_key
    cdt_key_cond #(.DEBOUNCE(DEBOUNCE), .DW(DW)) u_key (
      .clk_i     (clk),
      .rst_i     (rst),
      .sync_vld_i(sv_q[1]),
      .key_n_i   (key_raw[k]),
      .press_o   (ev[k])
    );
  end

  // Next-state: mode transitions, time arithmetic, prescaler and blink phase.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    preset_d  = preset_q;
    presc_d   = presc_q;
    blink_d   = blink_q;
    tick      = (presc_q == PW'(TICK_DIV - 1));
    presc_adv = tick ? '0 : presc_q + PW'(1);
    secs_q    = time_q / 19'd100;
    sec       = secs_q % 19'd60;
    sum       = time_q + 19'd6000;
    if (sum > 19'(MAX_TIME)) sum = sum - 19'(MAX_TIME + 1);
    case (state_q)
      S_SET: begin
        if (ev[2]) begin
          if (time_q != 19'd0) begin
            preset_d = time_q;
            state_d  = S_RUN;
            presc_d  = '0;
          end
        end else if (ev[1]) begin
          time_d = sum;
        end else if (ev[0]) begin
          time_d = time_q - sec * 19'd100
                 + ((sec == 19'd59) ? 19'd0 : sec + 19'd1) * 19'd100;
        end
      end
      S_RUN: begin
        presc_d = presc_adv;
        if (tick && time_q != 19'd0) time_d = time_q - 19'd1;
        if (tick && time_q == 19'd1) begin
          state_d = S_ALARM;
          blink_d = '0;
        end else if (ev[2]) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (ev[2]) begin
          state_d = S_RUN;
        end else if (ev[1]) begin
          state_d = S_SET;
          time_d  = preset_q;
          presc_d = '0;
        end
      end
      default: begin
        presc_d = presc_adv;
        time_d  = 19'd0;
        if (tick) blink_d = (blink_q == 7'd99) ? 7'd0 : blink_q + 7'd1;
        if (|ev) begin
          state_d = S_SET;
          time_d  = preset_q;
          presc_d = '0;
          blink_d = '0;
        end
      end
    endcase
    secs_d = time_d / 19'd100;
    dig    = 4'(secs_d % 19'd10);
    case (state_d)
      S_RUN, S_PAUSE: led_d = 10'd1 << (4'd9 - dig);
      S_ALARM:        led_d = (blink_d < 7'd50) ? 10'h3FF : 10'h000;
      default:        led_d = 10'h000;
    endcase
  end

  // State and registered outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SET;
      time_q    <= '0;
      preset_q  <= '0;
      presc_q   <= '0;
      blink_q   <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      preset_q  <= preset_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
      led_q     <= led_d;
    end
  end

  assign time_remaining = time_q;
  assign running        = running_q;
  assign alarm          = alarm_q;
  assign led            = led_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: per-cycle behavioural model plus pinned literal checks.
module tb_countdown_timer;
  localparam int TD  = 4;
  localparam int DB  = 2;
  localparam int LAT = DB + 4;   // key driven after edge c -> action on edge c+LAT

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        k2 = 1'b1, k1 = 1'b1, k0 = 1'b1;
  logic [18:0] time_remaining;
  logic        running, alarm;
  logic [9:0]  led;

  countdown_timer #(.TICK_DIV(TD), .DEBOUNCE(DB), .MAX_TIME(359999)) dut (
    .clk(clk), .rst(rst), .key2(k2), .key1(k1), .key0(k0),
    .time_remaining(time_remaining), .running(running), .alarm(alarm), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ev_at [3] = '{-1, -1, -1};
  // model: st 0=SET 1=RUN 2=PAUSE 3=ALARM
  int m_st = 0, m_t = 0, m_pre = 0, m_ph = 0, m_at = 0;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  string lit_name = "";
  int lit_field = 0, lit_exp = 0, lit_seq = 0, lit_done = 0;

  // Reference behaviour, written in minutes/seconds/centisecond arithmetic.
  always @(posedge clk) begin
    bit e2, e1, e0;
    cyc++;
    if (rst) begin
      m_st = 0; m_t = 0; m_pre = 0; m_ph = 0; m_at = 0;
    end else begin
      e2 = (ev_at[2] == cyc); e1 = (ev_at[1] == cyc); e0 = (ev_at[0] == cyc);
      case (m_st)
        0: if (e2) begin
             if (m_t != 0) begin m_pre = m_t; m_st = 1; m_ph = 0; end
           end else if (e1) m_t = ((m_t / 6000 + 1) % 60) * 6000 + m_t % 6000;
           else if (e0) m_t = (m_t / 6000) * 6000 + (((m_t / 100) % 60 + 1) % 60) * 100 + m_t % 100;
        1: begin
             m_ph++;
             if (m_ph == TD) begin m_ph = 0; m_t--; end
             if (m_t == 0) begin m_st = 3; m_at = 0; end
             else if (e2) m_st = 2;
           end
        2: if (e2) m_st = 1;
           else if (e1) begin m_st = 0; m_t = m_pre; m_ph = 0; end
        default: begin
             m_ph++;
             if (m_ph == TD) begin m_ph = 0; m_at++; end
             if (e2 || e1 || e0) begin m_st = 0; m_t = m_pre; m_ph = 0; end
           end
      endcase
    end
  end

  function automatic int exp_led();
    if (m_st == 1 || m_st == 2) return 1 << (9 - (m_t / 100) % 10);
    if (m_st == 3) return ((m_at / 50) % 2 == 0) ? 'h3FF : 0;
    return 0;
  endfunction

  // Single compare process: model every cycle, plus any posted literal expectation.
  always @(negedge clk) begin
    int act, el;
    if (chk_en) begin
      el = exp_led();
      n_cmp++;
      if (int'(time_remaining) != m_t || running != (m_st == 1) ||
          alarm != (m_st == 3) || int'(led) != el) begin
        n_bad++;
        $display("FAIL model cyc=%0d time got %0d want %0d, running got %0b want %0b, alarm got %0b want %0b, led got %h want %h",
                 cyc, time_remaining, m_t, running, m_st == 1, alarm, m_st == 3, led, el[9:0]);
      end
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        case (lit_field)
          0: act = int'(time_remaining);
          1: act = int'(running);
          2: act = int'(alarm);
          default: act = int'(led);
        endcase
        n_cmp++;
        if (act != lit_exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got %0d want %0d", lit_name, cyc, act, lit_exp);
        end
      end
    end
  end

  // Post a literal expectation; it is checked at the next falling edge.
  task automatic lit(input string nm, input int fld, input int ex);
    #1;
    lit_name = nm; lit_field = fld; lit_exp = ex; lit_seq++;
    @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m);
    for (int k = 0; k < 3; k++) if (m[k]) ev_at[k] = cyc + LAT;
    {k2, k1, k0} = ~m;
    repeat (6) @(negedge clk);
    {k2, k1, k0} = 3'b111;
    repeat (6) @(negedge clk);
  endtask

  task automatic press_n(input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_alarm(input int budget);
    for (int i = 0; i < budget && !alarm; i++) @(negedge clk);
  endtask

  initial begin
    // T1 reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    lit("t1_time", 0, 0);
    lit("t1_running", 1, 0);
    lit("t1_alarm", 2, 0);
    lit("t1_led", 3, 0);
    repeat (4) @(negedge clk);

    // T2 minute/second wrap and glitch rejection
    press_n(3'b010, 61);
    lit("t2_min_wrap", 0, 6000);
    press_n(3'b001, 75);
    lit("t2_sec_wrap", 0, 7500);
    k1 = 1'b0; @(negedge clk); k1 = 1'b1;
    repeat (10) @(negedge clk);
    lit("t2_glitch", 0, 7500);

    // T3 3 s run to alarm and blink
    do_rst(1); repeat (5) @(negedge clk);
    press_n(3'b001, 3);
    lit("t3_preset", 0, 300);
    press(3'b100);
    lit("t3_running", 1, 1);
    wait_alarm(1400);
    lit("t3_alarm", 2, 1);
    lit("t3_led_lit", 3, 'h3FF);
    repeat (198) @(negedge clk);
    lit("t3_led_dark", 3, 0);
    press(3'b001);
    lit("t3_back_to_preset", 0, 300);

    // T4 pause / resume / abort
    do_rst(1); repeat (5) @(negedge clk);
    press_n(3'b001, 2);
    press(3'b100);
    repeat (28) @(negedge clk);
    press(3'b100);               // lands on a tick edge: decrement and pause
    repeat (100) @(negedge clk);
    lit("t4_frozen", 0, 190);
    lit("t4_paused", 1, 0);
    press(3'b100);
    repeat (9) @(negedge clk);
    press(3'b100);
    press(3'b001);               // ignored in PAUSE
    press(3'b100);
    repeat (5) @(negedge clk);
    press(3'b100);
    press(3'b010);
    lit("t4_abort", 0, 200);

    // T5 zero start ignored, simultaneous key2+key0
    do_rst(1); repeat (5) @(negedge clk);
    press(3'b100);
    lit("t5_zero_start", 1, 0);
    press(3'b001);
    press(3'b101);
    lit("t5_sim_time", 0, 99);
    lit("t5_sim_running", 1, 1);

    // T6 reset mid-run, in alarm, and with a key held through reset
    repeat (10) @(negedge clk);
    do_rst(1);
    lit("t6_run_rst_time", 0, 0);
    lit("t6_run_rst_running", 1, 0);
    repeat (5) @(negedge clk);
    press(3'b001);
    press(3'b100);
    wait_alarm(500);
    lit("t6_alarm", 2, 1);
    do_rst(1);
    lit("t6_alarm_rst_alarm", 2, 0);
    lit("t6_alarm_rst_led", 3, 0);
    k0 = 1'b0;
    do_rst(2);
    repeat (12) @(negedge clk);
    k0 = 1'b1;
    repeat (10) @(negedge clk);
    lit("t6_held_no_event", 0, 0);
    press(3'b001);
    lit("t6_press_after", 0, 100);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
